mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the MEM stage.
// It registers one load/store request, waits for the memory to answer or
// time out, and stalls the upstream pipeline for the whole access.
// It then releases the stall for one DONE cycle so the MEM instruction
// advances to WB exactly once.
module mem_access_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ReadDataM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushW,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Last counter value before the access is abandoned (counter starts at 0).
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic       stall;

    // Saturating wait-cycle counter increment.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // Access FSM with the memory-side request registers and captured load data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= 32'd0;
            dmem_wdata  <= 32'd0;
            ReadDataM   <= 32'd0;
            wait_cnt    <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MemReqM) begin
                        state      <= WAIT;
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWriteM;
                        dmem_addr  <= ALUResultM;
                        dmem_wdata <= WriteDataM;
                        wait_cnt   <= 8'd0;
                    end
                end
                WAIT: begin
                    wait_cnt <= sat_inc(wait_cnt);
                    if (dmem_ready) begin
                        // Ready takes priority over a coincident timeout.
                        if (!dmem_we) begin
                            ReadDataM <= dmem_rdata;
                        end
                        dmem_req <= 1'b0;
                        state    <= DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        ReadDataM   <= 32'd0;
                        timeout_err <= 1'b1;
                        dmem_req    <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

    // Hold the pipeline while a request is being accepted or is outstanding;
    // the same condition bubbles WB so a held instruction is written only once.
    always_comb begin
        stall = ((state == IDLE) && MemReqM) || (state == WAIT);
    end

    assign StallF = stall;
    assign StallD = stall;
    assign StallE = stall;
    assign StallM = stall;
    assign FlushW = stall;
    assign busy   = (state != IDLE);

endmodule
